// File: rtl/ctx_pkg.sv
// Shared types and command-field layout for the CTX byte responder.
// Imported by the interface, register file and engine.
package ctx_pkg;

  typedef enum logic [1:0] {
    OpRead  = 2'b00,
    OpWrite = 2'b01,
    OpAdd   = 2'b10,
    OpClear = 2'b11
  } op_e;

  typedef enum logic {
    StIdle,
    StData
  } state_e;

  localparam int unsigned OpMsb  = 7;
  localparam int unsigned OpLsb  = 6;
  localparam int unsigned RsvMsb = 5;
  localparam int unsigned RsvLsb = 4;
  localparam int unsigned IdxMsb = 3;
  localparam int unsigned IdxLsb = 0;

  localparam logic [7:0] DefaultErrByte = 8'hEE;

  function automatic op_e cmd_op(logic [7:0] b);
    return op_e'(b[OpMsb:OpLsb]);
  endfunction

endpackage

// File: rtl/ctx_if.sv
// CTX byte interface: initiator drives val/in, responder returns out/busy/err.
// Clock and reset stay outside the bundle.
interface ctx_if;
  logic       val;
  logic [7:0] in;
  logic [7:0] out;
  logic       busy;
  logic       err;

  modport master (output val, output in, input out, input busy, input err);
  modport slave (input val, input in, output out, output busy, output err);
endinterface

// File: rtl/ctx_regfile.sv
// Bank of 8-bit context registers: one synchronous write port, one
// combinational read port, all entries cleared on rst.
module ctx_regfile #(
  parameter int unsigned NumCtx = 16,
  parameter int unsigned IdxW   = $clog2(NumCtx)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  logic [7:0]      wdata_i,
  input  logic [IdxW-1:0] raddr_i,
  output logic [7:0]      rdata_o
);

  logic [7:0] mem_q [NumCtx];
  logic [7:0] mem_d [NumCtx];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ctx_engine.sv
// CTX responder: decodes command bytes, runs READ/WRITE/ADD/CLEAR against the
// context bank and returns a registered result byte one cycle later.
module ctx_engine
  import ctx_pkg::*;
#(
  parameter int unsigned NUM_CTX  = 16,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  ERR_BYTE = DefaultErrByte
) (
  input  logic clk,
  input  logic rst,
  ctx_if.slave bus
);

  localparam int unsigned IdxW   = $clog2(NUM_CTX);
  localparam int unsigned TimerW = $clog2(TIMEOUT + 2);
  // Abort fires on the idle cycle that would bring the count to TIMEOUT.
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        out_q, out_d;
  logic              err_q, err_d;

  logic            we;
  logic [7:0]      wdata;
  logic [7:0]      rd_data;
  logic [IdxW-1:0] rd_idx;

  logic [3:0]      cmd_idx_raw;
  logic [IdxW-1:0] cmd_idx;
  logic            cmd_legal;

  assign cmd_idx_raw = bus.in[IdxMsb:IdxLsb];
  assign cmd_idx     = cmd_idx_raw[IdxW-1:0];
  assign cmd_legal   = (bus.in[RsvMsb:RsvLsb] == 2'b00) && (32'(cmd_idx_raw) < NUM_CTX);
  // In DATA the bank is addressed by the latched index, otherwise by the command.
  assign rd_idx      = (state_q == StData) ? idx_q : cmd_idx;

  ctx_regfile #(
    .NumCtx (NUM_CTX),
    .IdxW   (IdxW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (rd_idx),
    .wdata_i (wdata),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    out_d   = out_q;
    err_d   = 1'b0;
    we      = 1'b0;
    wdata   = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (bus.val) begin
          if (!cmd_legal) begin
            out_d = ERR_BYTE;
            err_d = 1'b1;
          end else begin
            unique case (cmd_op(bus.in))
              OpRead: out_d = rd_data;
              OpClear: begin
                we    = 1'b1;
                out_d = 8'h00;
              end
              default: begin
                op_d    = cmd_op(bus.in);
                idx_d   = cmd_idx;
                timer_d = '0;
                state_d = StData;
              end
            endcase
          end
        end
      end
      StData: begin
        if (bus.val) begin
          we      = 1'b1;
          wdata   = (op_q == OpAdd) ? rd_data + bus.in : bus.in;
          out_d   = wdata;
          timer_d = '0;
          state_d = StIdle;
        end else if ((TIMEOUT != 0) && (timer_q == TimeoutLast)) begin
          out_d   = ERR_BYTE;
          err_d   = 1'b1;
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpRead;
      idx_q   <= '0;
      timer_q <= '0;
      out_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q == StData);
  assign bus.err  = err_q;

endmodule
